// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, nop word, branch-target alignment.
package fetch_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST           = 32'h0000_0000;
  localparam int          ENTRY_W            = 64;
  localparam logic [31:0] BRANCH_ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] BRANCH_PC_STEP     = 32'd4;

  function automatic logic [31:0] branch_align(input logic [31:0] addr);
    return addr & BRANCH_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bundle: redirect/hold from the pipeline, imem handshake, head instruction to decode.
interface fetch_buffer_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] inst;
  logic [31:0] pc4;
  logic        inst_valid;

  modport master (
    input  redirect, redirect_pc, hold, mem_ack, mem_data,
    output mem_req, mem_addr, inst, pc4, inst_valid
  );

  modport slave (
    output redirect, redirect_pc, hold, mem_ack, mem_data,
    input  mem_req, mem_addr, inst, pc4, inst_valid
  );
endinterface

// File: rtl/fetch_buffer_fifo_sync.sv
// Synchronous FIFO with flush and occupancy output; DEPTH must be a power of two.
module fifo_sync #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch queue: single-outstanding imem requester feeding a FIFO of {addr, data}.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no request outstanding
// ST_REQ     | request at pc_q outstanding, data will be enqueued on ack
// ST_DISCARD | request at stale_q outstanding for a flushed path, drop on ack
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst_n,
  fetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        stale_q, stale_d;
  logic               push, pop, flush;
  logic [ENTRY_W-1:0] head;
  logic [CW-1:0]      count;
  logic [CW:0]        occ_next;
  logic               space_ok;
  logic               inst_valid;

  fifo_sync #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  ({pc_q, bus.mem_data}),
    .data_o  (head),
    .count_o (count)
  );

  assign inst_valid = (count != '0);
  assign flush      = bus.redirect;
  assign push       = (state_q == ST_REQ) && bus.mem_ack && !bus.redirect;
  assign pop        = inst_valid && !bus.hold && !bus.redirect;

  // Occupancy after this edge; a new request is only raised if it still fits.
  assign occ_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign space_ok = occ_next < (CW+1)'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.redirect)  pc_d    = branch_align(bus.redirect_pc);
        else if (space_ok) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.redirect) begin
          pc_d = branch_align(bus.redirect_pc);
          if (bus.mem_ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
            stale_d = pc_q;
          end
        end else if (bus.mem_ack) begin
          pc_d    = pc_q + BRANCH_PC_STEP;
          state_d = space_ok ? ST_REQ : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (bus.redirect) pc_d    = branch_align(bus.redirect_pc);
        if (bus.mem_ack)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The stale address keeps mem_addr stable while the flushed request drains.
  assign bus.mem_req    = (state_q != ST_IDLE);
  assign bus.mem_addr   = (state_q == ST_REQ)     ? pc_q    :
                          (state_q == ST_DISCARD) ? stale_q : 32'h0;
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = inst_valid ? head[31:0] : NOP_INST;
  assign bus.pc4        = inst_valid ? head[63:32] + BRANCH_PC_STEP : 32'h0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer; imem returns mem_addr ^ 32'hDEAD_0000 with ack driven by the bench.
module tb_fetch_buffer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   enq_cnt;
  int   pc4_bad;

  fetch_buffer_if bus();

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = bus.mem_addr ^ 32'hDEAD_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.hold        = 1'b0;
    bus.mem_ack     = 1'b1;

    // Streaming fetch, ack tied high
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",    32'(bus.mem_req), 32'd0);
    check("rst_mem_addr",   bus.mem_addr, 32'h0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst",       bus.inst, 32'h0);
    check("rst_pc4",        bus.pc4, 32'h0);
    rst_n = 1'b1;
    step();
    check("s_e1_req",   32'(bus.mem_req), 32'd1);
    check("s_e1_addr",  bus.mem_addr, 32'h0);
    check("s_e1_valid", 32'(bus.inst_valid), 32'd0);
    step();
    check("s_e2_valid", 32'(bus.inst_valid), 32'd1);
    check("s_e2_pc4",   bus.pc4, 32'h4);
    check("s_e2_inst",  bus.inst, 32'hDEAD_0000);
    check("s_e2_addr",  bus.mem_addr, 32'h4);
    step();
    check("s_e3_pc4",   bus.pc4, 32'h8);
    check("s_e3_addr",  bus.mem_addr, 32'h8);
    step();
    check("s_e4_pc4",   bus.pc4, 32'hC);
    check("s_e4_inst",  bus.inst, 32'hDEAD_0008);

    // Hold with ack high fills exactly DEPTH entries
    bus.hold    = 1'b1;
    bus.mem_ack = 1'b1;
    do_reset();
    enq_cnt = 0;
    pc4_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req) enq_cnt++;
      step();
      if (bus.inst_valid && bus.pc4 != 32'h4) pc4_bad++;
    end
    check("h_enq_cnt",  32'(enq_cnt), 32'd4);
    check("h_req_low",  32'(bus.mem_req), 32'd0);
    check("h_pc4_bad",  32'(pc4_bad), 32'd0);
    check("h_pc4_head", bus.pc4, 32'h4);
    bus.hold    = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    check("h_out1_pc4", bus.pc4, 32'h8);
    step();
    check("h_out2_pc4", bus.pc4, 32'hC);
    step();
    check("h_out3_pc4", bus.pc4, 32'h10);
    check("h_out3_inst", bus.inst, 32'hDEAD_000C);

    // Redirect while a request is pending without ack
    bus.mem_ack     = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h10;
    do_reset();
    step();
    check("d_idle_redir_req", 32'(bus.mem_req), 32'd0);
    bus.redirect = 1'b0;
    step();
    check("d_req_addr", bus.mem_addr, 32'h10);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    check("d_disc_req",   32'(bus.mem_req), 32'd1);
    check("d_disc_addr",  bus.mem_addr, 32'h10);
    check("d_disc_valid", 32'(bus.inst_valid), 32'd0);
    step();
    step();
    bus.mem_ack = 1'b1;
    step();
    check("d_ack_valid", 32'(bus.inst_valid), 32'd0);
    check("d_ack_req",   32'(bus.mem_req), 32'd0);
    bus.mem_ack = 1'b0;
    step();
    check("d_new_addr",  bus.mem_addr, 32'h40);
    check("d_new_valid", 32'(bus.inst_valid), 32'd0);
    bus.mem_ack = 1'b1;
    step();
    check("d_new_enq_valid", 32'(bus.inst_valid), 32'd1);
    check("d_new_pc4",       bus.pc4, 32'h44);
    check("d_new_inst",      bus.inst, 32'hDEAD_0040);

    // Redirect beats hold on a full queue; low address bits dropped
    bus.hold = 1'b1;
    repeat (6) step();
    check("f_full_req", 32'(bus.mem_req), 32'd0);
    check("f_full_pc4", bus.pc4, 32'h44);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h103;
    step();
    check("f_flush_valid", 32'(bus.inst_valid), 32'd0);
    check("f_flush_req",   32'(bus.mem_req), 32'd0);
    bus.redirect = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.hold     = 1'b0;
    step();
    check("f_new_req",  32'(bus.mem_req), 32'd1);
    check("f_new_addr", bus.mem_addr, 32'h100);

    // Redirect on the ack cycle, then fetch PC wrap
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    bus.mem_ack     = 1'b1;
    step();
    check("w_ackredir_req",   32'(bus.mem_req), 32'd0);
    check("w_ackredir_valid", 32'(bus.inst_valid), 32'd0);
    bus.redirect = 1'b0;
    bus.mem_ack  = 1'b0;
    step();
    check("w_top_addr", bus.mem_addr, 32'hFFFF_FFFC);
    bus.mem_ack = 1'b1;
    bus.hold    = 1'b1;
    step();
    check("w_valid",    32'(bus.inst_valid), 32'd1);
    check("w_pc4",      bus.pc4, 32'h0);
    check("w_inst",     bus.inst, 32'h2152_FFFC);
    check("w_next_addr", bus.mem_addr, 32'h0);

    // Asynchronous reset with three entries queued and a request pending
    step();
    step();
    check("r_pre_pc4",  bus.pc4, 32'h0);
    check("r_pre_addr", bus.mem_addr, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_async_req",   32'(bus.mem_req), 32'd0);
    check("r_async_addr",  bus.mem_addr, 32'h0);
    check("r_async_valid", 32'(bus.inst_valid), 32'd0);
    check("r_async_inst",  bus.inst, 32'h0);
    check("r_async_pc4",   bus.pc4, 32'h0);
    bus.hold = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("r_rel_req", 32'(bus.mem_req), 32'd0);
    step();
    check("r_e1_req",   32'(bus.mem_req), 32'd1);
    check("r_e1_addr",  bus.mem_addr, 32'h0);
    check("r_e1_valid", 32'(bus.inst_valid), 32'd0);
    step();
    check("r_e2_valid", 32'(bus.inst_valid), 32'd1);
    check("r_e2_pc4",   bus.pc4, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries in the queue (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 redirect  input  1  branch taken from MEM stage; flush queue and refetch.
REQ-006 redirect_pc  input  32  branch target; bits [1:0] ignored, treated as 0.
REQ-007 hold  input  1  load-use stall from decode; head entry is not consumed.
REQ-008 mem_req  output  1  instruction memory read request.
REQ-009 mem_addr  output  32  word-aligned fetch address, valid while mem_req=1.
REQ-010 mem_ack  input  1  memory accepts request; mem_data valid in the same cycle.
REQ-011 mem_data  input  32  fetched instruction word.
REQ-012 inst  output  32  head instruction to decode; 32'h0 (nop) when queue empty.
REQ-013 pc4  output  32  head entry address + 4; 32'h0 when queue empty.
REQ-014 inst_valid  output  1  queue non-empty; head on inst/pc4 is meaningful.

Function
REQ-015 Queue SHALL be a DEPTH-entry FIFO of {addr, data}; inst/pc4/inst_valid driven combinationally from head.
REQ-016 Dequeue SHALL occur on a rising edge when inst_valid=1, hold=0, redirect=0.
REQ-017 Enqueue SHALL occur on a rising edge when mem_req=1, mem_ack=1, state=REQ, redirect=0.
REQ-018 Simultaneous enqueue and dequeue SHALL both take effect; occupancy unchanged.
REQ-019 At most one memory request SHALL be outstanding; mem_req and mem_addr held stable until mem_ack.
REQ-020 New request SHALL be raised only when occupancy + outstanding < DEPTH (never overflows).
REQ-021 Fetch PC SHALL increment by 4 on each accepted request, wrapping modulo 2^32.
REQ-022 FSM states: IDLE (no request), REQ (request pending), DISCARD (pending request belongs to stale path).
REQ-023 IDLE->REQ when space available; REQ->IDLE on ack with no space remaining, else stays REQ with next address.
REQ-024 redirect in IDLE or on the ack cycle of REQ: queue emptied, fetch PC := redirect_pc, next state IDLE, new request raised the following cycle.
REQ-025 redirect in REQ without ack: queue emptied, fetch PC := redirect_pc, state -> DISCARD; request kept until ack.
REQ-026 DISCARD: returned data dropped, not enqueued; on ack -> IDLE; another redirect in DISCARD updates fetch PC only.
REQ-027 redirect SHALL take priority over hold, dequeue and enqueue in the same cycle.
REQ-028 Latency: mem_ack at edge N with empty queue -> inst_valid=1 after edge N; redirect at edge N -> mem_req with redirect_pc after edge N+1 at earliest.
REQ-029 hold with empty queue SHALL have no effect; fetching continues under hold until full.

Reset
REQ-030 On rst_n=0: queue empty, inst_valid=0, inst=0, pc4=0, mem_req=0, mem_addr=0, state IDLE, fetch PC=RESET_PC.
REQ-031 Reset asserted mid-request SHALL abandon the request; any mem_ack after release while IDLE is ignored.
REQ-032 First mem_req SHALL assert on the first edge after rst_n deasserts, mem_addr=RESET_PC.

Structure
REQ-033 FSM state encoding and the nop constant SHALL live in the shared CPU defines include with BRANCH_* constants.
REQ-034 Storage SHALL be one sub-module fifo_sync (DEPTH, width 64, push/pop/flush, count out); FSM and PC logic stay in fetch_buffer.

Verification
REQ-035 Reset, mem_ack tied 1, hold=0 -> mem_addr 0,4,8,...; inst_valid=1 from second edge; pc4 sequence 4,8,12.
REQ-036 mem_ack=1, hold=1 for 10 cycles -> exactly 4 enqueues, mem_req low, head pc4=4 constant; release -> 4,8,12,16 in order.
REQ-037 Request at addr 0x10 pending, redirect_pc=0x40 without ack, ack 3 cycles later -> data dropped, next mem_addr=0x40, inst_valid=0 until its ack.
REQ-038 redirect=1 and hold=1 with full queue, redirect_pc=0x103 -> queue empty next cycle, next mem_addr=0x100.
REQ-039 Fetch PC 0xFFFF_FFFC, ack -> next mem_addr 0x0, enqueued pc4=0x0.
REQ-040 rst_n pulsed low mid-request with 3 entries queued -> all outputs 0 immediately; restart at RESET_PC.
